pong_game_engine: RTL and testbench

Game-state stage directly upstream of the VGA renderer in display_pong. It consumes the 1-cycle frame_start pulse from the VGA timing block and button inputs. Once per frame it advances ball position and direction, moves and clamps the paddle, and detects wall bounces, paddle hits and misses. It produces ball_x, ball_y, paddle_x and paddle_y (all centre/edge coordinates in 640x480 pixel space) plus hit and miss counters for the renderer and score display.

---
 rtl/pong_pkg.sv | 30 +++
 rtl/pong_paddle_ctrl.sv | 45 ++++
 rtl/pong_game_engine.sv | 168 ++++++++++++++++
 tb/tb_pong_game_engine.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/pong_pkg.sv
// Shared pong definitions: FSM state encodings, default geometry and speeds,
// and the serve position. Used by the engine, display_pong and the renderer.
package pong_pkg;

  localparam int H_RES_DEF        = 640;
  localparam int V_RES_DEF        = 480;
  localparam int BALL_R_DEF       = 4;
  localparam int PAD_W_DEF        = 8;
  localparam int PAD_H_DEF        = 32;
  localparam int SPEED_X_DEF      = 2;
  localparam int SPEED_Y_DEF      = 2;
  localparam int PAD_SPEED_DEF    = 4;
  localparam int SERVE_FRAMES_DEF = 60;

  localparam int COORD_W     = 10;
  localparam int COUNT_W     = 8;
  localparam int SERVE_CNT_W = 8;

  localparam logic [COORD_W-1:0] CENTRE_X = 10'd320;
  localparam logic [COORD_W-1:0] CENTRE_Y = 10'd240;

  localparam logic [0:0] ST_PLAY  = 1'b0;
  localparam logic [0:0] ST_SERVE = 1'b1;

  function automatic logic [COORD_W-1:0] abs_diff(input logic [COORD_W-1:0] a,
                                                  input logic [COORD_W-1:0] b);
    return (a > b) ? (a - b) : (b - a);
  endfunction

endpackage

// File: rtl/pong_paddle_ctrl.sv
// Paddle vertical position: button decode and a clamped centre register,
// advanced only on the per-frame update strobe.
module pong_paddle_ctrl
  import pong_pkg::*;
#(
  parameter int V_RES     = V_RES_DEF,
  parameter int PAD_H     = PAD_H_DEF,
  parameter int PAD_SPEED = PAD_SPEED_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               update,
  input  logic               btn_up,
  input  logic               btn_down,
  output logic [COORD_W-1:0] paddle_y
);

  localparam logic [COORD_W-1:0] Y_MIN    = COORD_W'(PAD_H);
  localparam logic [COORD_W-1:0] UP_LIMIT = COORD_W'(PAD_H + PAD_SPEED);
  localparam logic [COORD_W:0]   Y_MAX    = (COORD_W+1)'(V_RES - 1 - PAD_H);
  localparam logic [COORD_W:0]   STEP     = (COORD_W+1)'(PAD_SPEED);

  logic [COORD_W:0]   down_sum;
  logic [COORD_W-1:0] y_next;

  assign down_sum = {1'b0, paddle_y} + STEP;

  always_comb begin
    y_next = paddle_y;
    if (btn_up && !btn_down) begin
      y_next = (paddle_y < UP_LIMIT) ? Y_MIN : paddle_y - COORD_W'(PAD_SPEED);
    end else if (btn_down && !btn_up) begin
      y_next = (down_sum > Y_MAX) ? Y_MAX[COORD_W-1:0] : down_sum[COORD_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      paddle_y <= CENTRE_Y;
    end else if (update) begin
      paddle_y <= y_next;
    end
  end

endmodule

// File: rtl/pong_game_engine.sv
// Per-frame pong game state: ball physics with wall/paddle reflection,
// miss handling with a timed serve, and hit/miss counters.
//   state    | meaning
//   ST_PLAY  | ball moving, collisions evaluated each update
//   ST_SERVE | ball held at centre after a miss, serve_cnt counting down
module pong_game_engine
  import pong_pkg::*;
#(
  parameter int H_RES        = H_RES_DEF,
  parameter int V_RES        = V_RES_DEF,
  parameter int BALL_R       = BALL_R_DEF,
  parameter int PAD_W        = PAD_W_DEF,
  parameter int PAD_H        = PAD_H_DEF,
  parameter int SPEED_X      = SPEED_X_DEF,
  parameter int SPEED_Y      = SPEED_Y_DEF,
  parameter int PAD_SPEED    = PAD_SPEED_DEF,
  parameter int SERVE_FRAMES = SERVE_FRAMES_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               frame_start,
  input  logic               pause,
  input  logic               btn_up,
  input  logic               btn_down,
  output logic [COORD_W-1:0] ball_x,
  output logic [COORD_W-1:0] ball_y,
  output logic [COORD_W-1:0] paddle_x,
  output logic [COORD_W-1:0] paddle_y,
  output logic [COUNT_W-1:0] hit_count,
  output logic [COUNT_W-1:0] miss_count,
  output logic               miss_pulse,
  output logic               serving
);

  localparam logic [COORD_W:0]   X_RIGHT   = (COORD_W+1)'(H_RES - 1 - BALL_R);
  localparam logic [COORD_W:0]   Y_BOTTOM  = (COORD_W+1)'(V_RES - 1 - BALL_R);
  localparam logic [COORD_W:0]   STEP_X    = (COORD_W+1)'(SPEED_X);
  localparam logic [COORD_W:0]   STEP_Y    = (COORD_W+1)'(SPEED_Y);
  localparam logic [COORD_W-1:0] Y_TOP     = COORD_W'(BALL_R);
  localparam logic [COORD_W-1:0] Y_TOP_TRG = COORD_W'(BALL_R + SPEED_Y);
  localparam logic [COORD_W-1:0] X_PADDLE  = COORD_W'(PAD_W + BALL_R);
  localparam logic [COORD_W-1:0] X_PAD_TRG = COORD_W'(PAD_W + BALL_R + SPEED_X);
  localparam logic [COORD_W-1:0] HIT_WIN   = COORD_W'(PAD_H + BALL_R);

  logic                   update;
  logic [0:0]             state;
  logic [SERVE_CNT_W-1:0] serve_cnt;
  logic                   dir_x_right;
  logic                   dir_y_down;

  logic [COORD_W:0]   x_sum;
  logic [COORD_W:0]   y_sum;
  logic [COORD_W-1:0] x_next;
  logic [COORD_W-1:0] y_next;
  logic               dir_x_next;
  logic               dir_y_next;
  logic               hit;
  logic               miss;

  assign update   = frame_start && !pause;
  assign paddle_x = '0;
  assign serving  = (state == ST_SERVE);

  // Wall tests use the 11-bit stepped value, equivalent to comparing the
  // current position against the limit minus the step.
  assign x_sum = {1'b0, ball_x} + STEP_X;
  assign y_sum = {1'b0, ball_y} + STEP_Y;

  pong_paddle_ctrl #(
    .V_RES    (V_RES),
    .PAD_H    (PAD_H),
    .PAD_SPEED(PAD_SPEED)
  ) u_paddle (
    .clk     (clk),
    .reset   (reset),
    .update  (update),
    .btn_up  (btn_up),
    .btn_down(btn_down),
    .paddle_y(paddle_y)
  );

  always_comb begin
    y_next     = ball_y;
    dir_y_next = dir_y_down;
    if (dir_y_down) begin
      if (y_sum > Y_BOTTOM) begin
        y_next     = Y_BOTTOM[COORD_W-1:0];
        dir_y_next = 1'b0;
      end else begin
        y_next = y_sum[COORD_W-1:0];
      end
    end else begin
      if (ball_y < Y_TOP_TRG) begin
        y_next     = Y_TOP;
        dir_y_next = 1'b1;
      end else begin
        y_next = ball_y - COORD_W'(SPEED_Y);
      end
    end
  end

  // Paddle check uses the paddle position from before this update.
  always_comb begin
    x_next     = ball_x;
    dir_x_next = dir_x_right;
    hit        = 1'b0;
    miss       = 1'b0;
    if (dir_x_right) begin
      if (x_sum > X_RIGHT) begin
        x_next     = X_RIGHT[COORD_W-1:0];
        dir_x_next = 1'b0;
      end else begin
        x_next = x_sum[COORD_W-1:0];
      end
    end else if (ball_x < X_PAD_TRG) begin
      if (abs_diff(ball_y, paddle_y) <= HIT_WIN) begin
        hit        = 1'b1;
        x_next     = X_PADDLE;
        dir_x_next = 1'b1;
      end else begin
        miss = 1'b1;
      end
    end else begin
      x_next = ball_x - COORD_W'(SPEED_X);
    end
  end

  always_ff @(posedge clk) begin
    miss_pulse <= 1'b0;
    if (reset) begin
      state       <= ST_PLAY;
      serve_cnt   <= '0;
      ball_x      <= CENTRE_X;
      ball_y      <= CENTRE_Y;
      dir_x_right <= 1'b1;
      dir_y_down  <= 1'b1;
      hit_count   <= '0;
      miss_count  <= '0;
    end else if (update) begin
      case (state)
        ST_PLAY: begin
          if (miss) begin
            state       <= ST_SERVE;
            serve_cnt   <= SERVE_CNT_W'(SERVE_FRAMES - 1);
            ball_x      <= CENTRE_X;
            ball_y      <= CENTRE_Y;
            dir_x_right <= 1'b1;
            dir_y_down  <= 1'b1;
            miss_count  <= miss_count + 1'b1;
            miss_pulse  <= 1'b1;
          end else begin
            ball_x      <= x_next;
            ball_y      <= y_next;
            dir_x_right <= dir_x_next;
            dir_y_down  <= dir_y_next;
            if (hit) hit_count <= hit_count + 1'b1;
          end
        end
        ST_SERVE: begin
          if (serve_cnt == '0) state <= ST_PLAY;
          else                 serve_cnt <= serve_cnt - 1'b1;
        end
        default: state <= ST_PLAY;
      endcase
    end
  end

endmodule

// File: tb/tb_pong_game_engine.sv
// Directed bench for pong_game_engine with hand-computed trajectory checkpoints.
module tb_pong_game_engine;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       frame_start = 1'b0;
  logic       pause = 1'b0;
  logic       btn_up = 1'b0;
  logic       btn_down = 1'b0;
  logic [9:0] ball_x, ball_y, paddle_x, paddle_y;
  logic [7:0] hit_count, miss_count;
  logic       miss_pulse, serving;

  int n_checks = 0;
  int n_fail   = 0;

  pong_game_engine dut (
    .clk        (clk),
    .reset      (reset),
    .frame_start(frame_start),
    .pause      (pause),
    .btn_up     (btn_up),
    .btn_down   (btn_down),
    .ball_x     (ball_x),
    .ball_y     (ball_y),
    .paddle_x   (paddle_x),
    .paddle_y   (paddle_y),
    .hit_count  (hit_count),
    .miss_count (miss_count),
    .miss_pulse (miss_pulse),
    .serving    (serving)
  );

  always #5 clk = ~clk;

  // Each frame: one-cycle pulse, outputs observed at the following negedge.
  task automatic run_frames(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk) frame_start = 1'b1;
      @(negedge clk) frame_start = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; frame_start = 1'b0; pause = 1'b0; btn_up = 1'b0; btn_down = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    repeat (10) @(negedge clk);
    n_checks++; if (ball_x !== 10'd320) begin n_fail++; $display("FAIL reset_ball_x got %0d want 320", ball_x); end
    n_checks++; if (ball_y !== 10'd240) begin n_fail++; $display("FAIL reset_ball_y got %0d want 240", ball_y); end
    n_checks++; if (paddle_x !== 10'd0) begin n_fail++; $display("FAIL reset_paddle_x got %0d want 0", paddle_x); end
    n_checks++; if (paddle_y !== 10'd240) begin n_fail++; $display("FAIL reset_paddle_y got %0d want 240", paddle_y); end
    n_checks++; if (hit_count !== 8'd0 || miss_count !== 8'd0) begin n_fail++; $display("FAIL reset_counters got %0d/%0d want 0/0", hit_count, miss_count); end
    n_checks++; if (serving !== 1'b0 || miss_pulse !== 1'b0) begin n_fail++; $display("FAIL reset_flags got %b/%b want 0/0", serving, miss_pulse); end
  endtask

  task automatic test_motion_pause();
    do_reset();
    run_frames(4);
    @(negedge clk) frame_start = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (ball_x !== 10'd330 || ball_y !== 10'd250) begin n_fail++; $display("FAIL latency1 got (%0d,%0d) want (330,250)", ball_x, ball_y); end
    @(negedge clk) frame_start = 1'b0;
    pause = 1'b1;
    btn_down = 1'b1;
    run_frames(3);
    n_checks++; if (ball_x !== 10'd330 || ball_y !== 10'd250) begin n_fail++; $display("FAIL pause_ball got (%0d,%0d) want (330,250)", ball_x, ball_y); end
    n_checks++; if (paddle_y !== 10'd240) begin n_fail++; $display("FAIL pause_paddle got %0d want 240", paddle_y); end
    pause = 1'b0; btn_down = 1'b0;
    repeat (5) @(negedge clk);
    n_checks++; if (ball_x !== 10'd330 || ball_y !== 10'd250) begin n_fail++; $display("FAIL no_event_hold got (%0d,%0d) want (330,250)", ball_x, ball_y); end
  endtask

  task automatic test_paddle();
    do_reset();
    btn_up = 1'b1;
    run_frames(51);
    n_checks++; if (paddle_y !== 10'd36) begin n_fail++; $display("FAIL paddle_up_step got %0d want 36", paddle_y); end
    run_frames(9);
    n_checks++; if (paddle_y !== 10'd32) begin n_fail++; $display("FAIL paddle_top_clamp got %0d want 32", paddle_y); end
    btn_down = 1'b1;
    run_frames(5);
    n_checks++; if (paddle_y !== 10'd32) begin n_fail++; $display("FAIL paddle_both got %0d want 32", paddle_y); end
    btn_up = 1'b0;
    run_frames(1);
    n_checks++; if (paddle_y !== 10'd36) begin n_fail++; $display("FAIL paddle_down_step got %0d want 36", paddle_y); end
    run_frames(150);
    n_checks++; if (paddle_y !== 10'd447) begin n_fail++; $display("FAIL paddle_bottom_clamp got %0d want 447", paddle_y); end
    btn_down = 1'b0;
  endtask

  task automatic test_walls_hit();
    do_reset();
    run_frames(117);
    n_checks++; if (ball_y !== 10'd474 || ball_x !== 10'd554) begin n_fail++; $display("FAIL frame117 got (%0d,%0d) want (554,474)", ball_x, ball_y); end
    run_frames(1);
    n_checks++; if (ball_y !== 10'd475) begin n_fail++; $display("FAIL bottom_clamp got %0d want 475", ball_y); end
    run_frames(1);
    n_checks++; if (ball_y !== 10'd473) begin n_fail++; $display("FAIL bottom_dir_up got %0d want 473", ball_y); end
    run_frames(38);
    n_checks++; if (ball_x !== 10'd634) begin n_fail++; $display("FAIL frame157_x got %0d want 634", ball_x); end
    run_frames(1);
    n_checks++; if (ball_x !== 10'd635) begin n_fail++; $display("FAIL right_clamp got %0d want 635", ball_x); end
    run_frames(1);
    n_checks++; if (ball_x !== 10'd633) begin n_fail++; $display("FAIL right_dir_left got %0d want 633", ball_x); end
    run_frames(195);
    n_checks++; if (ball_y !== 10'd4 || ball_x !== 10'd243) begin n_fail++; $display("FAIL top_clamp got (%0d,%0d) want (243,4)", ball_x, ball_y); end
    run_frames(115);
    n_checks++; if (ball_x !== 10'd13 || ball_y !== 10'd234) begin n_fail++; $display("FAIL frame469 got (%0d,%0d) want (13,234)", ball_x, ball_y); end
    run_frames(1);
    n_checks++; if (ball_x !== 10'd12 || ball_y !== 10'd236) begin n_fail++; $display("FAIL paddle_hit_pos got (%0d,%0d) want (12,236)", ball_x, ball_y); end
    n_checks++; if (hit_count !== 8'd1 || miss_count !== 8'd0) begin n_fail++; $display("FAIL hit_counters got %0d/%0d want 1/0", hit_count, miss_count); end
    run_frames(1);
    n_checks++; if (ball_x !== 10'd14 || ball_y !== 10'd238) begin n_fail++; $display("FAIL after_hit got (%0d,%0d) want (14,238)", ball_x, ball_y); end
  endtask

  task automatic test_miss_serve();
    do_reset();
    btn_up = 1'b1;
    run_frames(469);
    n_checks++; if (ball_x !== 10'd13 || paddle_y !== 10'd32 || miss_pulse !== 1'b0) begin n_fail++; $display("FAIL pre_miss got x=%0d pad=%0d mp=%b want 13/32/0", ball_x, paddle_y, miss_pulse); end
    run_frames(1);
    n_checks++; if (miss_pulse !== 1'b1) begin n_fail++; $display("FAIL miss_pulse_high got %b want 1", miss_pulse); end
    n_checks++; if (miss_count !== 8'd1 || hit_count !== 8'd0) begin n_fail++; $display("FAIL miss_counters got %0d/%0d want 1/0", miss_count, hit_count); end
    n_checks++; if (ball_x !== 10'd320 || ball_y !== 10'd240 || serving !== 1'b1) begin n_fail++; $display("FAIL miss_recentre got (%0d,%0d) srv=%b want (320,240) 1", ball_x, ball_y, serving); end
    @(negedge clk);
    n_checks++; if (miss_pulse !== 1'b0) begin n_fail++; $display("FAIL miss_pulse_width got %b want 0", miss_pulse); end
    run_frames(59);
    n_checks++; if (serving !== 1'b1 || ball_x !== 10'd320 || ball_y !== 10'd240) begin n_fail++; $display("FAIL serve_hold got srv=%b (%0d,%0d) want 1 (320,240)", serving, ball_x, ball_y); end
    run_frames(1);
    n_checks++; if (serving !== 1'b0 || ball_x !== 10'd320 || ball_y !== 10'd240) begin n_fail++; $display("FAIL serve_exit got srv=%b (%0d,%0d) want 0 (320,240)", serving, ball_x, ball_y); end
    run_frames(1);
    n_checks++; if (ball_x !== 10'd322 || ball_y !== 10'd242) begin n_fail++; $display("FAIL serve_first_move got (%0d,%0d) want (322,242)", ball_x, ball_y); end
    btn_up = 1'b0;
  endtask

  task automatic test_reset_mid_serve();
    do_reset();
    btn_up = 1'b1;
    run_frames(480);
    n_checks++; if (serving !== 1'b1 || miss_count !== 8'd1) begin n_fail++; $display("FAIL mid_serve got srv=%b miss=%0d want 1/1", serving, miss_count); end
    do_reset();
    @(negedge clk);
    n_checks++; if (serving !== 1'b0 || miss_count !== 8'd0 || hit_count !== 8'd0) begin n_fail++; $display("FAIL reset_in_serve got srv=%b miss=%0d hit=%0d want 0/0/0", serving, miss_count, hit_count); end
    n_checks++; if (ball_x !== 10'd320 || ball_y !== 10'd240 || paddle_y !== 10'd240) begin n_fail++; $display("FAIL reset_in_serve_pos got (%0d,%0d) pad=%0d want (320,240) 240", ball_x, ball_y, paddle_y); end
    run_frames(1);
    n_checks++; if (ball_x !== 10'd322 || ball_y !== 10'd242) begin n_fail++; $display("FAIL play_after_reset got (%0d,%0d) want (322,242)", ball_x, ball_y); end
  endtask

  initial begin
    test_reset();
    test_motion_pause();
    test_paddle();
    test_walls_hit();
    test_miss_serve();
    test_reset_mid_serve();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
